// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the LEGv8 memory stage.
//   mem_fsm_t  - data-memory handshake states
//   XZR        - register index that always reads zero and discards writes
//   BYTE_MASK  - low-byte mask for LDURB/STURB zero-extension
package mem_stage_pkg;
    typedef enum logic {MS_IDLE, MS_WAIT} mem_fsm_t;
    localparam logic [4:0]  XZR       = 5'd31;
    localparam logic [63:0] BYTE_MASK = 64'hFF;
endpackage

// File: rtl/dmem_handshake.sv
// dmem_handshake: request/ready handshake FSM for the data memory.
//   clk, reset : clock, asynchronous active-high reset
//   pending    : EX/MEM holds a load or store
//   ready      : memory accepts/completes the request this cycle
//   req        : request valid (combinational on entering MEM)
//   stall      : freeze the upstream pipeline until ready
module dmem_handshake
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic pending,
    input  logic ready,
    output logic req,
    output logic stall
);
    mem_fsm_t state, state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MS_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        req        = pending || state == MS_WAIT;
        stall      = req && !ready;
        state_next = stall ? MS_WAIT : MS_IDLE;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: LEGv8 memory stage with EX/MEM and MEM/WB registers, flag register
// and a variable-latency data-memory handshake.
//   Ex*            : execute-stage results and control (captured into EX/MEM)
//   Dm*            : data-memory request/response interface
//   MemStall       : freezes IF/ID/EX and EX/MEM while an access waits
//   Mem*           : EX/MEM outputs (forward source MemALUOut)
//   Wb*            : MEM/WB outputs (forward source WbMemDataToReg)
//   FlagN/Z/V/C    : architectural condition flags
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ExALUOut,
    input  logic [DATA_W-1:0] ExFwdDb,
    input  logic              ExNegative,
    input  logic              ExZero,
    input  logic              ExOverflow,
    input  logic              ExCarryout,
    input  logic              ExSetFlags,
    input  logic              ExMemRead,
    input  logic              ExMemWrite,
    input  logic              ExByteOp,
    input  logic              ExMemToReg,
    input  logic              ExRegWrite,
    input  logic [RD_W-1:0]   ExRd,
    output logic              DmReq,
    output logic              DmWrEn,
    output logic              DmByte,
    output logic [DATA_W-1:0] DmAddr,
    output logic [DATA_W-1:0] DmWrData,
    input  logic              DmReady,
    input  logic [DATA_W-1:0] DmRdData,
    output logic              MemStall,
    output logic [DATA_W-1:0] MemALUOut,
    output logic [RD_W-1:0]   MemRd,
    output logic              MemRegWrite,
    output logic [DATA_W-1:0] WbMemDataToReg,
    output logic [RD_W-1:0]   WbRd,
    output logic              WbRegWrite,
    output logic              FlagN,
    output logic              FlagZ,
    output logic              FlagV,
    output logic              FlagC
);
    logic              mem_read, mem_write, mem_byte, mem_to_reg, mem_reg_write_raw;
    logic [DATA_W-1:0] mem_db, load_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MemALUOut         <= '0;
            mem_db            <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_byte          <= 1'b0;
            mem_to_reg        <= 1'b0;
            mem_reg_write_raw <= 1'b0;
            MemRd             <= '0;
        end else if (!MemStall) begin
            MemALUOut         <= ExALUOut;
            mem_db            <= ExFwdDb;
            mem_read          <= ExMemRead;
            mem_write         <= ExMemWrite;
            mem_byte          <= ExByteOp;
            mem_to_reg        <= ExMemToReg;
            mem_reg_write_raw <= ExRegWrite;
            MemRd             <= ExRd;
        end
    end

    // Flags commit with the instruction entering EX/MEM, so a stalled SUBS waits too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        {FlagN, FlagZ, FlagV, FlagC} <= 4'b0;
        else if (ExSetFlags && !MemStall) {FlagN, FlagZ, FlagV, FlagC} <= {ExNegative, ExZero, ExOverflow, ExCarryout};
    end

    // Writes to XZR are dropped here so neither forwarding nor writeback sees them.
    assign MemRegWrite = mem_reg_write_raw && MemRd != RD_W'(XZR);

    dmem_handshake u_hs (
        .clk    (clk),
        .reset  (reset),
        .pending(mem_read || mem_write),
        .ready  (DmReady),
        .req    (DmReq),
        .stall  (MemStall)
    );

    assign DmAddr    = MemALUOut;
    assign DmWrEn    = mem_write;
    assign DmByte    = mem_byte;
    assign DmWrData  = mem_byte ? mem_db & DATA_W'(BYTE_MASK) : mem_db;
    assign load_data = mem_byte ? DmRdData & DATA_W'(BYTE_MASK) : DmRdData;

    // A stalled cycle pushes a bubble into WB but keeps the last forwarded value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WbMemDataToReg <= '0;
            WbRd           <= '0;
            WbRegWrite     <= 1'b0;
        end else if (MemStall) begin
            WbRegWrite     <= 1'b0;
        end else begin
            WbMemDataToReg <= mem_to_reg ? load_data : MemALUOut;
            WbRd           <= MemRd;
            WbRegWrite     <= MemRegWrite;
        end
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage 64-bit LEGv8 pipeline. Sits directly after the execute stage.
- Consumes the execute results: ALU result, forwarded Db, flags and control.
- Holds the EX/MEM and MEM/WB pipeline registers, the architectural flag register, and a variable-latency data-memory request/ready handshake.
- Produces MemALUOut and WbMemDataToReg, the two values the execute-stage forwarding muxes select.

Parameters:
DATA_W, 64, datapath/address width
RD_W, 5, destination register index width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ExALUOut  input  DATA_W  ALU result / memory address from execute
ExFwdDb  input  DATA_W  forwarded Db (store data)
ExNegative, ExZero, ExOverflow, ExCarryout  input  1 each  execute flags
ExSetFlags  input  1  instruction updates flag register (ADDS/SUBS)
ExMemRead  input  1  load
ExMemWrite  input  1  store
ExByteOp  input  1  LDURB/STURB byte access
ExMemToReg  input  1  writeback selects load data
ExRegWrite  input  1  instruction writes Rd
ExRd  input  RD_W  destination register
DmReq  output  1  data-memory request valid
DmWrEn  output  1  request is a write
DmByte  output  1  request is byte-sized
DmAddr  output  DATA_W  request address
DmWrData  output  DATA_W  store data
DmReady  input  1  memory accepts/completes the request this cycle
DmRdData  input  DATA_W  load data, valid when DmReady
MemStall  output  1  freeze IF/ID/EX and EX/MEM
MemALUOut  output  DATA_W  EX/MEM ALU result (forward source)
MemRd  output  RD_W  EX/MEM Rd
MemRegWrite  output  1  EX/MEM RegWrite, gated for X31
WbMemDataToReg  output  DATA_W  MEM/WB writeback value (forward source)
WbRd  output  RD_W  MEM/WB Rd
WbRegWrite  output  1  MEM/WB RegWrite
FlagN, FlagZ, FlagV, FlagC  output  1 each  architectural flags

Behaviour:
Reset:
- Async reset clears all registers, flags and the FSM (FSM goes to MS_IDLE).
- Every output is 0 during reset, including DmReq. An in-flight request is abandoned; a late DmReady is ignored.

EX/MEM register:
- Loads all Ex* inputs on every rising edge while MemStall=0.
- Holds while MemStall=1.

Flag register:
- When ExSetFlags=1 and MemStall=0, FlagN/Z/V/C load ExNegative/ExZero/ExOverflow/ExCarryout on the same edge as EX/MEM.
- Otherwise the flags hold.

Memory access (EX/MEM holds a load or store):
- DmReq is combinational on entering the MEM cycle.
- DmAddr=MemALUOut. DmWrEn=stored MemWrite. DmByte=stored ByteOp.
- DmWrData = ByteOp ? {56'b0, Db[7:0]} : Db.
- The request fields stay stable until DmReady.

FSM (MS_IDLE, MS_WAIT):
- In MS_IDLE with an access pending:
  - DmReady=1: the access completes with zero wait and MemStall=0.
  - DmReady=0: MemStall=1 and the FSM goes to MS_WAIT.
- In MS_WAIT:
  - DmReq=1 and MemStall=1 until DmReady=1.
  - In the DmReady cycle MemStall=0, the access completes and the FSM returns to MS_IDLE.
- A non-memory instruction never asserts DmReq or MemStall.
- Back-to-back accesses: the next access issues in the cycle after completion, with no idle cycle required.

MEM/WB register:
- On completion, or when there is no access, it loads:
  - WbMemDataToReg = MemToReg ? (ByteOp ? {56'b0, DmRdData[7:0]} : DmRdData) : MemALUOut.
  - WbRd = MemRd.
  - WbRegWrite = MemRegWrite.
- While MemStall=1, WbRegWrite loads 0 (a bubble). WbMemDataToReg and WbRd hold.

Other rules:
- X31: MemRegWrite is forced to 0 when MemRd=31, so WbRegWrite is 0 for that instruction.
- Latency: Ex inputs reach Mem* outputs after 1 edge and Wb* outputs after 2 edges, plus the wait cycles.
- A store with DmReady=1 in its first MEM cycle causes no stall.

Decomposition:
- Package mem_stage_pkg holds:
  - typedef enum mem_fsm_t {MS_IDLE, MS_WAIT};
  - localparam XZR = 5'd31;
  - localparam BYTE_MASK = 64'hFF.
- One sub-module, dmem_handshake: owns the FSM and generates DmReq and MemStall from the pending flag and DmReady.

Test Plan:
- ALU passthrough: ADD with ExALUOut=0x1234, ExRd=3, RegWrite=1 -> MemALUOut=0x1234 after 1 edge; WbMemDataToReg=0x1234, WbRd=3, WbRegWrite=1 after 2 edges; DmReq never 1.
- Zero-wait load: ExMemRead=1, MemToReg=1, addr 0x40, DmReady tied 1, DmRdData=0xDEADBEEF_CAFEF00D -> DmReq=1 with DmAddr=0x40 for 1 cycle; MemStall=0; WbMemDataToReg=0xDEADBEEF_CAFEF00D.
- 3-wait store: STURB with Db=0xAABB, addr 0x80, DmReady low for 3 cycles -> MemStall=1 for 3 cycles; DmWrData=0xBB and DmByte=1 stable throughout; 3 bubble cycles with WbRegWrite=0; EX/MEM held.
- Byte load zero-extend: LDURB with DmRdData=0xFFFF_FFFF_FFFF_FF80 -> WbMemDataToReg=0x80.
- Flags: SUBS with N=1,Z=0,V=0,C=1 and ExSetFlags=1 -> Flags=1001; next ADD with ExSetFlags=0 and different flag inputs -> Flags unchanged; SUBS presented during a stall -> Flags unchanged until the stall clears.
- Reset mid-wait and XZR: assert reset in MS_WAIT -> DmReq=0, all outputs 0 immediately, FSM in MS_IDLE; after release, ADD with ExRd=31 -> MemRegWrite=0, WbRegWrite=0.
